// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request channel plus the
// instruction queue head presented to decode.
//   master (fetch unit): drives imem_req/imem_addr and inst_valid/inst_data/inst_pc,
//                        samples imem_gnt/imem_rvalid/imem_rdata and inst_ready.
//   slave  (memory + decode side): the mirror image.
interface ifu_fetch_if #(
  parameter int unsigned CPU_WIDTH = 32
) ();

  logic                 imem_req;
  logic [CPU_WIDTH-1:0] imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [CPU_WIDTH-1:0] imem_rdata;

  logic                 inst_valid;
  logic                 inst_ready;
  logic [CPU_WIDTH-1:0] inst_data;
  logic [CPU_WIDTH-1:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit. Owns the fetch PC, issues one word request at a
// time to instruction memory (req/gnt/rvalid) and buffers returned words with
// their PCs in a 2-entry FIFO read by decode (valid/ready).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ena             fetch enable (0 = no new requests)
//   redirect_valid  redirect to redirect_pc (low two bits ignored)
//   curr_pc         fetch PC register
//   bus             ifu_fetch_if master: imem_* request channel, inst_* queue head
module ifu_fetch #(
  parameter int unsigned          CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned          BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic [CPU_WIDTH-1:0] curr_pc,
  ifu_fetch_if.master          bus
);

  localparam logic [2:0] Depth = 3'(BUF_DEPTH);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDropReq, StDrop} state_e;

  state_e               state_q, state_d;
  logic [CPU_WIDTH-1:0] curr_pc_q, curr_pc_d;
  logic [CPU_WIDTH-1:0] addr_q, addr_d;
  logic [CPU_WIDTH-1:0] data_q [2];
  logic [CPU_WIDTH-1:0] data_d [2];
  logic [CPU_WIDTH-1:0] pc_q [2];
  logic [CPU_WIDTH-1:0] pc_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;

  logic                 push, pop, issue;
  logic [2:0]           count_nxt;
  logic [CPU_WIDTH-1:0] target;
  logic                 unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];
  assign target         = {redirect_pc[CPU_WIDTH-1:2], 2'b00};

  always_comb begin
    pop       = (count_q != 2'd0) && bus.inst_ready;
    push      = (state_q == StWait) && bus.imem_rvalid && !redirect_valid;
    count_nxt = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};
    // Only evaluated where nothing is outstanding after this cycle, so the
    // queue occupancy after this cycle's push/pop is the whole budget.
    issue     = ena && !redirect_valid && (count_nxt < Depth);
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    curr_pc_d = curr_pc_q;
    addr_d    = addr_q;

    unique case (state_q)
      StIdle: begin
        if (redirect_valid) begin
          if (ena) begin
            state_d = StReq;
            addr_d  = target;
          end
        end else if (issue) begin
          state_d = StReq;
          addr_d  = curr_pc_q;
        end
      end
      StReq: begin
        if (bus.imem_gnt) begin
          curr_pc_d = curr_pc_q + CPU_WIDTH'(4);
          state_d   = redirect_valid ? StDrop : StWait;
        end else if (redirect_valid) begin
          state_d = StDropReq;
        end
      end
      StWait: begin
        if (bus.imem_rvalid) begin
          if (redirect_valid) begin
            state_d = ena ? StReq : StIdle;
            addr_d  = target;
          end else if (issue) begin
            state_d = StReq;
            addr_d  = curr_pc_q;
          end else begin
            state_d = StIdle;
          end
        end else if (redirect_valid) begin
          state_d = StDrop;
        end
      end
      StDropReq: begin
        if (bus.imem_gnt) state_d = StDrop;
      end
      StDrop: begin
        if (bus.imem_rvalid) begin
          state_d = ena ? StReq : StIdle;
          addr_d  = redirect_valid ? target : curr_pc_q;
        end
      end
      default: state_d = StIdle;
    endcase

    // Redirect wins over the post-grant increment.
    if (redirect_valid) curr_pc_d = target;
  end

  // Instruction queue next state; a redirect flushes it.
  always_comb begin
    data_d = data_q;
    pc_d   = pc_q;
    if (push) begin
      data_d[wr_ptr_q] = bus.imem_rdata;
      pc_d[wr_ptr_q]   = addr_q;
    end
    if (redirect_valid) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      count_d  = count_nxt[1:0];
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      curr_pc_q <= RESET_PC;
      addr_q    <= RESET_PC;
      data_q[0] <= '0;
      data_q[1] <= '0;
      pc_q[0]   <= '0;
      pc_q[1]   <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      curr_pc_q <= curr_pc_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      pc_q      <= pc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    curr_pc        = curr_pc_q;
    bus.imem_req   = (state_q == StReq) || (state_q == StDropReq);
    bus.imem_addr  = addr_q;
    bus.inst_valid = (count_q != 2'd0);
    bus.inst_data  = bus.inst_valid ? data_q[rd_ptr_q] : '0;
    bus.inst_pc    = bus.inst_valid ? pc_q[rd_ptr_q] : '0;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a per-cycle vector table covering streaming,
// back-pressure and fetch disable, followed by hand-written redirect, wrap and
// reset sequences.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] curr_pc;

  int n_tests = 0;
  int n_fail  = 0;

  ifu_fetch_if #(.CPU_WIDTH(32)) bus ();

  ifu_fetch #(
    .CPU_WIDTH(32),
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .curr_pc       (curr_pc),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ena;
    logic        rv;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_idata;
    logic [31:0] e_cpc;
  } vec_t;

  vec_t vecs [21];

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic vec_t mk(input logic en, input logic rv, input logic [31:0] rpc,
                              input logic gnt, input logic rvl, input logic [31:0] rd,
                              input logic rdy, input logic req, input logic [31:0] addr,
                              input logic iv, input logic [31:0] ipc,
                              input logic [31:0] idat, input logic [31:0] cpc);
    vec_t v;
    v.ena = en; v.rv = rv; v.rpc = rpc; v.gnt = gnt; v.rvalid = rvl; v.rdata = rd;
    v.rdy = rdy; v.e_req = req; v.e_addr = addr; v.e_iv = iv; v.e_ipc = ipc;
    v.e_idata = idat; v.e_cpc = cpc;
    return v;
  endfunction

  task automatic set_in(input logic en, input logic rv, input logic [31:0] rpc,
                        input logic gnt, input logic rvl, input logic [31:0] rd,
                        input logic rdy);
    ena             = en;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rvl;
    bus.imem_rdata  = rd;
    bus.inst_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_row(input int i, input vec_t v);
    logic [129:0] act, exp;
    act = {bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst_pc, bus.inst_data, curr_pc};
    exp = {v.e_req, v.e_addr, v.e_iv, v.e_ipc, v.e_idata, v.e_cpc};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row%0d {req,addr,iv,ipc,idata,cpc}: got %h expected %h", i, act, exp);
    end
  endtask

  // The queue must never be written while already holding two entries.
  always @(negedge clk) begin
    if (!rst && dut.push && (dut.count_q == 2'd2) && !dut.pop) begin
      n_fail++;
      $display("FAIL queue_overflow: push into full queue at %0t", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //              ena rv rpc gnt rvl rdata      rdy req addr  iv ipc    idata      cpc
    vecs[0]  = mk(1, 0, 0, 0, 0, 0,          1,  0, 32'h0,  0, 0,     0,         32'h0);
    vecs[1]  = mk(1, 0, 0, 1, 0, 0,          1,  1, 32'h0,  0, 0,     0,         32'h0);
    vecs[2]  = mk(1, 0, 0, 0, 1, dat(32'h0), 1,  0, 32'h0,  0, 0,     0,         32'h4);
    vecs[3]  = mk(1, 0, 0, 1, 0, 0,          1,  1, 32'h4,  1, 32'h0, dat(32'h0), 32'h4);
    vecs[4]  = mk(1, 0, 0, 0, 1, dat(32'h4), 1,  0, 32'h4,  0, 0,     0,         32'h8);
    vecs[5]  = mk(1, 0, 0, 1, 0, 0,          1,  1, 32'h8,  1, 32'h4, dat(32'h4), 32'h8);
    vecs[6]  = mk(1, 0, 0, 0, 1, dat(32'h8), 1,  0, 32'h8,  0, 0,     0,         32'hC);
    vecs[7]  = mk(1, 0, 0, 0, 0, 0,          0,  1, 32'hC,  1, 32'h8, dat(32'h8), 32'hC);
    vecs[8]  = mk(1, 0, 0, 1, 0, 0,          0,  1, 32'hC,  1, 32'h8, dat(32'h8), 32'hC);
    vecs[9]  = mk(1, 0, 0, 0, 1, dat(32'hC), 0,  0, 32'hC,  1, 32'h8, dat(32'h8), 32'h10);
    vecs[10] = mk(1, 0, 0, 0, 0, 0,          0,  0, 32'hC,  1, 32'h8, dat(32'h8), 32'h10);
    vecs[11] = mk(1, 0, 0, 0, 0, 0,          0,  0, 32'hC,  1, 32'h8, dat(32'h8), 32'h10);
    vecs[12] = mk(1, 0, 0, 0, 0, 0,          1,  0, 32'hC,  1, 32'h8, dat(32'h8), 32'h10);
    vecs[13] = mk(1, 0, 0, 1, 0, 0,          0,  1, 32'h10, 1, 32'hC, dat(32'hC), 32'h10);
    vecs[14] = mk(1, 0, 0, 0, 1, dat(32'h10), 1, 0, 32'h10, 1, 32'hC, dat(32'hC), 32'h14);
    vecs[15] = mk(1, 0, 0, 0, 0, 0,          1,  1, 32'h14, 1, 32'h10, dat(32'h10), 32'h14);
    vecs[16] = mk(0, 0, 0, 1, 0, 0,          1,  1, 32'h14, 0, 0,     0,         32'h14);
    vecs[17] = mk(0, 0, 0, 0, 1, dat(32'h14), 0, 0, 32'h14, 0, 0,     0,         32'h18);
    vecs[18] = mk(0, 0, 0, 0, 0, 0,          0,  0, 32'h14, 1, 32'h14, dat(32'h14), 32'h18);
    vecs[19] = mk(0, 0, 0, 0, 0, 0,          1,  0, 32'h14, 1, 32'h14, dat(32'h14), 32'h18);
    vecs[20] = mk(0, 0, 0, 0, 0, 0,          0,  0, 32'h14, 0, 0,     0,         32'h18);

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    // Streaming, back-pressure, refill after pop, fetch disable.
    for (int i = 0; i < 21; i++) begin
      set_in(vecs[i].ena, vecs[i].rv, vecs[i].rpc, vecs[i].gnt, vecs[i].rvalid,
             vecs[i].rdata, vecs[i].rdy);
      chk_row(i, vecs[i]);
      tick();
    end

    // Redirect while waiting for data: the pending response is dropped.
    set_in(1, 0, 0, 0, 0, 0, 1);            chk("t3_idle_no_req", 32'(bus.imem_req), 0); tick();
    set_in(1, 0, 0, 1, 0, 0, 1);            chk("t3_req_addr", bus.imem_addr, 32'h18); tick();
    set_in(1, 1, 32'h103, 0, 0, 0, 1);      chk("t3_wait_cpc", curr_pc, 32'h1C); tick();
    set_in(1, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
    chk("t3_redir_cpc", curr_pc, 32'h100);
    chk("t3_drop_no_req", 32'(bus.imem_req), 0);
    tick();
    set_in(1, 0, 0, 1, 0, 0, 1);
    chk("t3_target_addr", bus.imem_addr, 32'h100);
    chk("t3_target_req", 32'(bus.imem_req), 1);
    chk("t3_stale_dropped", 32'(bus.inst_valid), 0);
    tick();
    set_in(1, 0, 0, 0, 1, dat(32'h100), 1); chk("t3_empty", 32'(bus.inst_valid), 0); tick();
    set_in(1, 0, 0, 0, 0, 0, 0);
    chk("t3_head_pc", bus.inst_pc, 32'h100);
    chk("t3_head_data", bus.inst_data, dat(32'h100));
    chk("t3_next_addr", bus.imem_addr, 32'h104);
    tick();

    // Redirect while the request waits for a grant held low for three cycles.
    set_in(1, 1, 32'h200, 0, 0, 0, 0);      chk("t4_req_held", 32'(bus.imem_req), 1); tick();
    set_in(1, 0, 0, 0, 0, 0, 0);
    chk("t4_addr_stable0", bus.imem_addr, 32'h104);
    chk("t4_flushed", 32'(bus.inst_valid), 0);
    chk("t4_cpc_target", curr_pc, 32'h200);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0);            chk("t4_addr_stable1", bus.imem_addr, 32'h104); tick();
    set_in(1, 0, 0, 1, 0, 0, 0);            chk("t4_addr_stable2", bus.imem_addr, 32'h104); tick();
    set_in(1, 0, 0, 0, 1, 32'hBAD0_BAD0, 0); chk("t4_drop_no_req", 32'(bus.imem_req), 0); tick();
    set_in(1, 0, 0, 1, 0, 0, 1);
    chk("t4_target_addr", bus.imem_addr, 32'h200);
    chk("t4_stale_dropped", 32'(bus.inst_valid), 0);
    tick();
    set_in(1, 0, 0, 0, 1, dat(32'h200), 1); tick();
    set_in(1, 0, 0, 1, 0, 0, 0);            chk("t4_head_data", bus.inst_data, dat(32'h200)); tick();

    // Redirect with rvalid in WAIT and a decode handshake in the same cycle.
    set_in(1, 1, 32'h300, 0, 1, dat(32'h204), 1); chk("t5_head_pc", bus.inst_pc, 32'h200); tick();
    set_in(1, 0, 0, 0, 0, 0, 0);
    chk("t5_flushed", 32'(bus.inst_valid), 0);
    chk("t5_req_next", 32'(bus.imem_req), 1);
    chk("t5_target_addr", bus.imem_addr, 32'h300);
    tick();
    set_in(1, 0, 0, 1, 0, 0, 0);            tick();
    set_in(1, 0, 0, 0, 1, dat(32'h300), 0); tick();

    // PC wrap at the top of the address space.
    set_in(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0); chk("t6_head_pc", bus.inst_pc, 32'h300); tick();
    set_in(1, 0, 0, 1, 0, 0, 0);            chk("t6_cpc_aligned", curr_pc, 32'hFFFF_FFFC); tick();
    set_in(1, 0, 0, 0, 1, 0, 0);            tick();
    set_in(1, 0, 0, 1, 0, 0, 0);            chk("t6_top_addr", bus.imem_addr, 32'hFFFF_FFFC); tick();
    set_in(1, 0, 0, 0, 1, dat(32'hFFFF_FFFC), 0); chk("t6_wrap", curr_pc, 32'h0); tick();
    set_in(1, 0, 0, 1, 0, 0, 0);
    chk("t6_wrap_head", bus.inst_pc, 32'hFFFF_FFFC);
    chk("t6_wrap_addr", bus.imem_addr, 32'h0);
    tick();

    // Reset mid-WAIT with a queued entry.
    rst = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0);            chk("t6_pre_rst_valid", 32'(bus.inst_valid), 1); tick();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("t6_rst_req", 32'(bus.imem_req), 0);
    chk("t6_rst_addr", bus.imem_addr, 32'h0);
    chk("t6_rst_cpc", curr_pc, 32'h0);
    chk("t6_rst_valid", 32'(bus.inst_valid), 0);
    chk("t6_rst_ipc", bus.inst_pc, 32'h0);
    chk("t6_rst_idata", bus.inst_data, 32'h0);

    // Redirect from IDLE issues to the target the next cycle.
    set_in(1, 1, 32'h40, 0, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0);
    chk("idle_redir_req", 32'(bus.imem_req), 1);
    chk("idle_redir_addr", bus.imem_addr, 32'h40);
    chk("idle_redir_cpc", curr_pc, 32'h40);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
